return_address_stack: RTL and testbench
=======================================

# return_address_stack

Hardware return-address stack (RAS) that captures the call-site address produced by the instruction address generator and returns it on subroutine return. It sits beside the PC logic. On a call, the PC logic pushes its saved previous-PC value; on a return, the PC logic selects this block's RA output as the next PC and pops it. The block turns the single-level RA register path into a nested-call stack and adds full/empty status and sticky error reporting.

## Interface
- DEPTH, 8: number of stack entries; power of two, 2..64.
- AW, 32: address width; matches the PC width.
- RET_OFFSET, 1: constant added to PushAddr before storage, so the stored value is the return address.

- Clock  in  1  rising-edge clock shared with the PC logic.
- Reset_n  in  1  asynchronous, active-low reset.
- Push  in  1  call event; store PushAddr+RET_OFFSET on the next rising edge.
- Pop  in  1  return event; discard the top entry on the next rising edge.
- PushAddr  in  AW  call-site address; driven from the PC logic's saved previous PC.
- RA  out  AW  current top-of-stack return address; 0 when Empty.
- Empty  out  1  no valid entries.
- Full  out  1  Count == DEPTH.
- Count  out  $clog2(DEPTH+1)  number of valid entries.
- Overflow  out  1  sticky; a push was attempted while Full (non-wrap build only).
- Underflow  out  1  sticky; a pop was attempted while Empty.
- ClearErr  in  1  synchronous clear of Overflow and Underflow.

## Operation
- Storage is DEPTH×AW registers plus a top pointer TP (log2 DEPTH bits) and Count. Entries are not reset; only TP, Count and the flags are reset.
- RA is a combinational read of entry[TP-1 mod DEPTH], gated to 0 when Empty.
- Push only, not Full: entry[TP] <= (PushAddr + RET_OFFSET) mod 2^AW; TP <= TP+1 mod DEPTH; Count+1.
- Pop only, not Empty: TP <= TP-1 mod DEPTH; Count-1. Entry contents are unchanged.
- Push and Pop in the same cycle, not Empty: replace the top. entry[TP-1] <= PushAddr+RET_OFFSET; TP and Count are unchanged. This is the tail-call case.
- Push and Pop in the same cycle, Empty: behaves as a push only. Underflow is not set.
- Pop while Empty: no state change; Underflow <= 1.
- Push while Full: handled as set by RAS_WRAP_EN (see Configuration).
- ClearErr has priority over a same-cycle error set: the flags read 0 after that edge.
- Addition wraps silently: PushAddr = 2^AW-1 with RET_OFFSET 1 stores 0.

## Timing
- Reset (Reset_n low, asynchronous): TP=0, Count=0, Empty=1, Full=0, RA=0, Overflow=0, Underflow=0. Reset takes effect immediately, even mid-push; any partial write is discarded.
- Reset is released synchronously on the first Clock edge with Reset_n high.
- Push-to-RA latency is 1 cycle: RA shows the pushed value in the cycle after the Push edge.
- Pop-to-RA latency is 1 cycle: RA shows the next-older entry after the Pop edge.
- During the cycle Pop is asserted, RA still presents the entry being popped. The PC logic samples RA into PC on that same edge.
- Empty, Full and Count are registered-derived and change only on Clock edges (or asynchronously on reset).

## Configuration
- RAS_WRAP_EN defined: push while Full overwrites the oldest entry (circular). TP advances, Count stays at DEPTH, and Overflow is never set. Deep recursion therefore loses the oldest returns silently.
- RAS_WRAP_EN undefined: push while Full is dropped with no state change, and Overflow <= 1.

## Structure
- Package ras_pkg holds: default DEPTH/AW/RET_OFFSET localparams, the ras_op_e typedef (NOP, PUSH, POP, REPLACE) decoded from {Push,Pop}, and the count-width function.
- One sub-module, ras_regfile: DEPTH×AW storage with one write port and one asynchronous read port, and no reset. Pointer, count and flag logic stay in the top module.

## Test plan
- Reset with Reset_n=0 mid-cycle -> RA=0, Empty=1, Count=0, flags 0, immediately and without waiting for a clock edge.
- Push 0x10, 0x20, 0x30 -> RA=0x31, Count=3; Pop twice -> RA=0x21 then 0x11; Pop -> Empty=1, RA=0.
- Pop on empty -> Underflow=1, Count=0; ClearErr for 1 cycle -> Underflow=0.
- Push 9 addresses 0x100..0x108 with DEPTH=8. Without RAS_WRAP_EN -> Overflow=1, RA=0x108. With RAS_WRAP_EN -> RA=0x109, Count=8, and 8 pops return 0x109 down to 0x102.
- After Push 0x40, assert Push 0x50 and Pop together -> RA=0x51, Count=1.
- Push PushAddr=0xFFFFFFFF -> RA=0x00000000, with no error flag set.

Source files
------------

// File: rtl/ras_pkg.sv
// Shared defaults, operation decode and width helper for the return-address stack.
package ras_pkg;

  localparam int RAS_DEPTH      = 8;
  localparam int RAS_AW         = 32;
  localparam int RAS_RET_OFFSET = 1;

  // Encoding matches the {Push, Pop} input pair.
  typedef enum logic [1:0] {
    NOP     = 2'b00,
    POP     = 2'b01,
    PUSH    = 2'b10,
    REPLACE = 2'b11
  } ras_op_e;

  function automatic int ras_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ras_regfile.sv
// DEPTH x AW storage for the return-address stack: one write port, one async read port, no reset.
module ras_regfile #(
  parameter int DEPTH = 8,
  parameter int AW    = 32
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [AW-1:0]            wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [AW-1:0]            rdata_o
);

  logic [AW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/return_address_stack.sv
// Return-address stack beside the PC logic: nested call/return, full/empty status, sticky errors.
// Build option RAS_WRAP_EN: push while full overwrites the oldest entry instead of raising Overflow.
module return_address_stack
  import ras_pkg::*;
#(
  parameter int DEPTH      = RAS_DEPTH,
  parameter int AW         = RAS_AW,
  parameter int RET_OFFSET = RAS_RET_OFFSET
) (
  input  logic                          Clock,
  input  logic                          Reset_n,
  input  logic                          Push,
  input  logic                          Pop,
  input  logic [AW-1:0]                 PushAddr,
  input  logic                          ClearErr,
  output logic [AW-1:0]                 RA,
  output logic                          Empty,
  output logic                          Full,
  output logic [ras_cnt_w(DEPTH)-1:0]   Count,
  output logic                          Overflow,
  output logic                          Underflow
);

  localparam int TPW = $clog2(DEPTH);
  localparam int CW  = ras_cnt_w(DEPTH);

  logic [TPW-1:0] tp_q, tp_d, tp_m1;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d, unf_q, unf_d;
  logic           ovf_set, unf_set;
  logic           empty, full;
  logic           we;
  logic [TPW-1:0] waddr;
  logic [AW-1:0]  wdata, rdata;
  ras_op_e        op;

  assign op    = ras_op_e'({Push, Pop});
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign tp_m1 = tp_q - 1'b1;
  assign wdata = PushAddr + AW'(RET_OFFSET);

  always_comb begin
    we      = 1'b0;
    waddr   = tp_q;
    tp_d    = tp_q;
    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case (op)
      PUSH: begin
        if (!full) begin
          we    = 1'b1;
          tp_d  = tp_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
        end else begin
`ifdef RAS_WRAP_EN
          // When full, TP already points at the oldest slot, so this write evicts it.
          we   = 1'b1;
          tp_d = tp_q + 1'b1;
`else
          ovf_set = 1'b1;
`endif
        end
      end
      POP: begin
        if (!empty) begin
          tp_d  = tp_m1;
          cnt_d = cnt_q - 1'b1;
        end else begin
          unf_set = 1'b1;
        end
      end
      REPLACE: begin
        // Tail call: overwrite the top in place; on an empty stack this is a plain push.
        we = 1'b1;
        if (!empty) begin
          waddr = tp_m1;
        end else begin
          tp_d  = tp_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign ovf_d = ClearErr ? 1'b0 : (ovf_q | ovf_set);
  assign unf_d = ClearErr ? 1'b0 : (unf_q | unf_set);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      tp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Gating the write with Reset_n drops a push that is in flight when reset asserts.
  ras_regfile #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clk_i   (Clock),
    .we_i    (we & Reset_n),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (tp_m1),
    .rdata_o (rdata)
  );

  assign RA        = empty ? '0 : rdata;
  assign Empty     = empty;
  assign Full      = full;
  assign Count     = cnt_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;

endmodule

// File: tb/tb_return_address_stack.sv
// Randomised scoreboard bench for return_address_stack against a queue-based stack model.
module tb_return_address_stack;

  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          Clock = 1'b0;
  logic          Reset_n = 1'b0;
  logic          Push = 1'b0, Pop = 1'b0, ClearErr = 1'b0;
  logic [AW-1:0] PushAddr = '0;
  logic [AW-1:0] RA;
  logic          Empty, Full, Overflow, Underflow;
  logic [CW-1:0] Count;

  return_address_stack #(.DEPTH(DEPTH), .AW(AW), .RET_OFFSET(1)) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .Push      (Push),
    .Pop       (Pop),
    .PushAddr  (PushAddr),
    .ClearErr  (ClearErr),
    .RA        (RA),
    .Empty     (Empty),
    .Full      (Full),
    .Count     (Count),
    .Overflow  (Overflow),
    .Underflow (Underflow)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [AW-1:0] ra;
    int            cnt;
    bit            empty;
    bit            full;
    bit            ovf;
    bit            unf;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] stk[$];
  bit            m_ovf, m_unf;
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.cnt   = stk.size();
    e.ra    = (stk.size() == 0) ? '0 : stk[stk.size()-1];
    e.empty = (stk.size() == 0);
    e.full  = (stk.size() == DEPTH);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    return e;
  endfunction

  task automatic compare_all(input string tag, input exp_t e);
    check({tag, ".RA"}, RA, e.ra);
    check({tag, ".Count"}, AW'(Count), AW'(e.cnt));
    check({tag, ".Empty"}, AW'(Empty), AW'(e.empty));
    check({tag, ".Full"}, AW'(Full), AW'(e.full));
    check({tag, ".Overflow"}, AW'(Overflow), AW'(e.ovf));
    check({tag, ".Underflow"}, AW'(Underflow), AW'(e.unf));
  endtask

  // Reference: the stack is a plain queue, newest entry at the back.
  task automatic model_step(input bit ps, input bit pp, input logic [AW-1:0] addr, input bit clr);
    logic [AW-1:0] v;
    bit set_o, set_u;
    v = addr + 1;
    set_o = 0;
    set_u = 0;
    if (ps && pp && stk.size() > 0) begin
      stk[stk.size()-1] = v;
    end else if (ps) begin
      if (stk.size() < DEPTH) stk.push_back(v);
      else begin
`ifdef RAS_WRAP_EN
        void'(stk.pop_front());
        stk.push_back(v);
`else
        set_o = 1;
`endif
      end
    end else if (pp) begin
      if (stk.size() > 0) void'(stk.pop_back());
      else set_u = 1;
    end
    if (clr) begin
      m_ovf = 0;
      m_unf = 0;
    end else begin
      m_ovf = m_ovf | set_o;
      m_unf = m_unf | set_u;
    end
  endtask

  task automatic step(input bit ps, input bit pp, input logic [AW-1:0] addr, input bit clr);
    Push = ps;
    Pop = pp;
    PushAddr = addr;
    ClearErr = clr;
    @(posedge Clock);
    model_step(ps, pp, addr, clr);
    exp_q.push_back(snapshot());
    #1;
    Push = 0;
    Pop = 0;
    ClearErr = 0;
  endtask

  // Monitor: outputs are stable mid-cycle, one expectation per active edge.
  always @(negedge Clock) begin
    while (exp_q.size() > 0) begin
      compare_all("sb", exp_q.pop_front());
    end
  end

  task automatic async_reset_check();
    @(negedge Clock);
    #2;
    Push = 1;
    PushAddr = 32'hDEAD_0000;
    Reset_n = 0;
    #1;
    stk.delete();
    m_ovf = 0;
    m_unf = 0;
    compare_all("reset", snapshot());
    Push = 0;
    @(negedge Clock);
    #1;
    compare_all("reset_hold", snapshot());
    Reset_n = 1;
    @(negedge Clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t, limit %0d", $time, 200000);
    $fatal(1, "watchdog");
  end

  initial begin
    m_ovf = 0;
    m_unf = 0;
    #23;
    compare_all("por", snapshot());
    Reset_n = 1;
    @(negedge Clock);

    step(1, 0, 32'h10, 0);
    step(1, 0, 32'h20, 0);
    step(1, 0, 32'h30, 0);
    step(0, 1, '0, 0);
    step(0, 1, '0, 0);
    step(0, 1, '0, 0);
    step(0, 1, '0, 0);
    step(1, 1, 32'h77, 0);
    step(0, 1, '0, 0);
    step(0, 0, '0, 1);
    step(1, 0, 32'h40, 0);
    step(1, 1, 32'h50, 0);
    step(0, 1, '0, 0);
    step(1, 0, 32'hFFFF_FFFF, 0);
    step(0, 1, '0, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 32'h100 + i, 0);
    step(1, 1, 32'h200, 0);
    step(0, 1, '0, 1);
    for (int i = 0; i < 9; i++) step(0, 1, '0, 0);

    async_reset_check();

    for (int i = 0; i < 2000; i++) begin
      int r;
      logic [AW-1:0] a;
      r = $urandom_range(99);
      a = ($urandom_range(15) == 0) ? 32'hFFFF_FFFF : AW'($urandom);
      if (r < 45)      step(1, 0, a, $urandom_range(19) == 0);
      else if (r < 80) step(0, 1, a, $urandom_range(19) == 0);
      else if (r < 92) step(1, 1, a, $urandom_range(19) == 0);
      else             step(0, 0, a, $urandom_range(3) == 0);
      if (i == 1000) async_reset_check();
    end

    @(negedge Clock);
    @(negedge Clock);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
